// File: rtl/rreg_wb_arbiter.sv
// rreg_wb_arbiter: shares the single Rreg write port (wite/addr3/data3) between
// the ALU writeback requester (A) and the memory-load requester (M). Each
// requester feeds a small FIFO. A round-robin arbiter drains one entry per cycle
// into a registered write port. Combinational hazard flags tell decode when a
// source register still has a write in flight.
//
// Optional feature (macro RREG_WB_R0_DROP_EN): entries addressed to register 0
// are accepted and popped but never strobe wite, and never raise a hazard.
//
// Ports (top):
//   clk, rst                 clock (rising edge), async active-high reset
//   a_valid/a_ready/a_addr/a_data   A request handshake and payload
//   m_valid/m_ready/m_addr/m_data   M request handshake and payload
//   wite/addr3/data3         registered register-file write port
//   chk_addr1/chk_addr2      decode source addresses to check
//   hazard1/hazard2          pending-write flags for chk_addr1/chk_addr2

// Per-requester FIFO with occupancy bits for hazard lookup.
module rreg_wb_fifo #(
  parameter int unsigned AW      = 3,
  parameter int unsigned DW      = 16,
  parameter int unsigned FD      = 2,
  parameter bit          R0_DROP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          ready,
  output logic          nempty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          hit1,
  output logic          hit2
);

  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CW = $clog2(FD + 1);

  logic [AW-1:0] addr_q [FD];
  logic [DW-1:0] data_q [FD];
  logic [FD-1:0] vld_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on the registered count, so a full FIFO refuses a
  // push even in a cycle where it is being popped.
  assign ready     = (cnt_q < CW'(FD));
  assign nempty    = (cnt_q != '0);
  assign head_addr = addr_q[rd_q];
  assign head_data = data_q[rd_q];

  // Control state: pointers, count and per-slot occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push) begin
        vld_q[wr_q] <= 1'b1;
        wr_q        <= nxt(wr_q);
      end
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= nxt(rd_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Payload storage; occupancy bits qualify it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= push_addr;
      data_q[wr_q] <= push_data;
    end
  end

  // Match any occupied slot against both check addresses.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < int'(FD); i++) begin
      if (vld_q[i] && (!R0_DROP || (addr_q[i] != '0))) begin
        if (addr_q[i] == chk_addr1) hit1 = 1'b1;
        if (addr_q[i] == chk_addr2) hit2 = 1'b1;
      end
    end
  end

endmodule

module rreg_wb_arbiter #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16,
  parameter int unsigned FD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic          wite,
  output logic [AW-1:0] addr3,
  output logic [DW-1:0] data3,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          hazard1,
  output logic          hazard2
);

`ifdef RREG_WB_R0_DROP_EN
  localparam bit R0_DROP = 1'b1;
`else
  localparam bit R0_DROP = 1'b0;
`endif

  logic          a_push, m_push, a_pop, m_pop, a_ne, m_ne;
  logic [AW-1:0] a_head_addr, m_head_addr, sel_addr;
  logic [DW-1:0] a_head_data, m_head_data, sel_data;
  logic          a_hit1, a_hit2, m_hit1, m_hit2;
  logic          rr_m_q, rr_m_d, wr_en;
  logic          out_live;

  assign a_push = a_valid && a_ready;
  assign m_push = m_valid && m_ready;

  rreg_wb_fifo #(.AW(AW), .DW(DW), .FD(FD), .R0_DROP(R0_DROP)) u_a_fifo (
    .clk(clk), .rst(rst),
    .push(a_push), .push_addr(a_addr), .push_data(a_data),
    .pop(a_pop), .ready(a_ready), .nempty(a_ne),
    .head_addr(a_head_addr), .head_data(a_head_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hit1(a_hit1), .hit2(a_hit2)
  );

  rreg_wb_fifo #(.AW(AW), .DW(DW), .FD(FD), .R0_DROP(R0_DROP)) u_m_fifo (
    .clk(clk), .rst(rst),
    .push(m_push), .push_addr(m_addr), .push_data(m_data),
    .pop(m_pop), .ready(m_ready), .nempty(m_ne),
    .head_addr(m_head_addr), .head_data(m_head_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hit1(m_hit1), .hit2(m_hit2)
  );

  // Round-robin select: rr_m_q=1 favours M when both sides hold entries.
  // The pointer always moves to the side that was not served.
  always_comb begin
    a_pop    = a_ne && (!m_ne || !rr_m_q);
    m_pop    = m_ne && (!a_ne || rr_m_q);
    rr_m_d   = rr_m_q;
    if (a_pop) begin
      rr_m_d = 1'b1;
    end else if (m_pop) begin
      rr_m_d = 1'b0;
    end
    sel_addr = m_pop ? m_head_addr : a_head_addr;
    sel_data = m_pop ? m_head_data : a_head_data;
    wr_en    = (a_pop || m_pop) && (!R0_DROP || (sel_addr != '0));
  end

  // Registered write port; address/data hold when nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_m_q <= 1'b0;
      wite   <= 1'b0;
      addr3  <= '0;
      data3  <= '0;
    end else begin
      rr_m_q <= rr_m_d;
      wite   <= wr_en;
      if (wr_en) begin
        addr3 <= sel_addr;
        data3 <= sel_data;
      end
    end
  end

  // The output stage counts as in flight only while it is strobing.
  assign out_live = wite && (!R0_DROP || (addr3 != '0));
  assign hazard1  = a_hit1 || m_hit1 || (out_live && (addr3 == chk_addr1));
  assign hazard2  = a_hit2 || m_hit2 || (out_live && (addr3 == chk_addr2));

endmodule

// File: tb/tb_rreg_wb_arbiter.sv
// Directed bench for rreg_wb_arbiter: stimulus queues expected writes, a
// monitor pops and compares them whenever wite is high.
module tb_rreg_wb_arbiter;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, m_valid, m_ready;
  logic [AW-1:0] a_addr, m_addr, addr3, chk_addr1, chk_addr2;
  logic [DW-1:0] a_data, m_data, data3;
  logic          wite, hazard1, hazard2;

  always #5 clk = ~clk;

  rreg_wb_arbiter #(.AW(AW), .DW(DW), .FD(FD)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .wite(wite), .addr3(addr3), .data3(data3),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   wr_cnt   = 0;
  int   first_wr = -1;
  int   last_wr  = -1;
  logic mr_log [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk) begin
    wr_t e;
    if (wite === 1'b1) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr3, data3);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr3), 32'(e.addr));
        check("wr_data", 32'(data3), 32'(e.data));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drive both streams; each side advances only when its push was accepted.
  task automatic run_streams(input int na, input int nm);
    int   ia = 0;
    int   im = 0;
    int   it = 0;
    logic acc_a, acc_m;
    while ((ia < na || im < nm) && it < 100) begin
      a_valid = (ia < na);
      a_addr  = AW'(1 + ia);
      a_data  = DW'(32'hA000 + ia);
      m_valid = (im < nm);
      m_addr  = AW'(4 + im);
      m_data  = DW'(32'hB000 + im);
      acc_a   = a_valid && a_ready;
      acc_m   = m_valid && m_ready;
      if (it < 16) mr_log[it] = m_ready;
      @(negedge clk);
      if (acc_a) ia++;
      if (acc_m) im++;
      it++;
    end
    a_valid = 1'b0;
    m_valid = 1'b0;
    if (it >= 100) check("stream_timeout", 32'(it), 32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; m_valid = 1'b0;
    a_addr = '0; a_data = '0; m_addr = '0; m_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;

    // Reset state.
    #2;
    check("rst_wite", 32'(wite), 32'd0);
    check("rst_addr3", 32'(addr3), 32'd0);
    check("rst_data3", 32'(data3), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_m_ready", 32'(m_ready), 32'd1);
    check("rst_hazard1", 32'(hazard1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single A write: two-edge latency, one-cycle strobe, then hold.
    expect_wr(3'd3, 16'h1234);
    a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234;
    @(negedge clk);
    a_valid = 1'b0;
    check("lat_edge1_wite", 32'(wite), 32'd0);
    @(negedge clk);
    check("lat_edge2_wite", 32'(wite), 32'd1);
    check("lat_edge2_addr3", 32'(addr3), 32'd3);
    check("lat_edge2_data3", 32'(data3), 32'h1234);
    @(negedge clk);
    check("lat_edge3_wite", 32'(wite), 32'd0);
    check("lat_hold_addr3", 32'(addr3), 32'd3);
    check("lat_hold_data3", 32'(data3), 32'h1234);
    drain("t1_drain");

    // Both streams continuously: strict A,M alternation, no gaps.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_wr(AW'(1 + i), DW'(32'hA000 + i));
      expect_wr(AW'(4 + i), DW'(32'hB000 + i));
    end
    wr_cnt = 0; first_wr = -1; last_wr = -1;
    run_streams(4, 4);
    drain("t2_drain");
    check("t2_write_count", 32'(wr_cnt), 32'd8);
    check("t2_write_span", 32'(last_wr - first_wr + 1), 32'd8);

    // M fills while A keeps the arbiter busy; third M push is refused.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      expect_wr(AW'(1 + i), DW'(32'hA000 + i));
      expect_wr(AW'(4 + i), DW'(32'hB000 + i));
    end
    expect_wr(3'd4, 16'hA003);
    run_streams(4, 3);
    check("t3_m_ready_c1", 32'(mr_log[0]), 32'd1);
    check("t3_m_ready_c2", 32'(mr_log[1]), 32'd1);
    check("t3_m_ready_full", 32'(mr_log[2]), 32'd0);
    check("t3_m_ready_c4", 32'(mr_log[3]), 32'd1);
    drain("t3_drain");

    // Hazard on a single queued A write.
    do_reset();
    chk_addr1 = 3'd5; chk_addr2 = 3'd6;
    check("hz_idle_h1", 32'(hazard1), 32'd0);
    expect_wr(3'd5, 16'h0055);
    a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h0055;
    @(negedge clk);
    a_valid = 1'b0;
    check("hz_q_h1", 32'(hazard1), 32'd1);
    check("hz_q_h2", 32'(hazard2), 32'd0);
    @(negedge clk);
    check("hz_out_wite", 32'(wite), 32'd1);
    check("hz_out_h1", 32'(hazard1), 32'd1);
    check("hz_out_h2", 32'(hazard2), 32'd0);
    @(negedge clk);
    check("hz_done_h1", 32'(hazard1), 32'd0);
    drain("t4a_drain");

    // Hazard with one entry in each FIFO: output stage vs FIFO contents.
    do_reset();
    expect_wr(3'd5, 16'h5555);
    expect_wr(3'd6, 16'h6666);
    a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h5555;
    m_valid = 1'b1; m_addr = 3'd6; m_data = 16'h6666;
    @(negedge clk);
    a_valid = 1'b0; m_valid = 1'b0;
    check("hz2_q_h1", 32'(hazard1), 32'd1);
    check("hz2_q_h2", 32'(hazard2), 32'd1);
    @(negedge clk);
    check("hz2_a_out_h1", 32'(hazard1), 32'd1);
    check("hz2_a_out_h2", 32'(hazard2), 32'd1);
    @(negedge clk);
    check("hz2_m_out_h1", 32'(hazard1), 32'd0);
    check("hz2_m_out_h2", 32'(hazard2), 32'd1);
    @(negedge clk);
    check("hz2_done_h2", 32'(hazard2), 32'd0);
    drain("t4b_drain");

    // Reset mid-operation with entries queued in both FIFOs.
    do_reset();
    expect_wr(3'd1, 16'hA000);
    expect_wr(3'd4, 16'hB000);
    chk_addr1 = 3'd2;
    run_streams(3, 2);
    check("t5_pre_h1", 32'(hazard1), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_wite", 32'(wite), 32'd0);
    check("t5_rst_addr3", 32'(addr3), 32'd0);
    check("t5_rst_data3", 32'(data3), 32'd0);
    check("t5_rst_a_ready", 32'(a_ready), 32'd1);
    check("t5_rst_m_ready", 32'(m_ready), 32'd1);
    check("t5_rst_h1", 32'(hazard1), 32'd0);
    check("t5_issued_before_rst", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (8) @(negedge clk);
    check("t5_no_write_after_rst", 32'(wr_cnt), 32'd0);

`ifdef RREG_WB_R0_DROP_EN
    // Register-0 entries are consumed silently and never flag a hazard.
    do_reset();
    chk_addr1 = 3'd0; chk_addr2 = 3'd1;
    expect_wr(3'd1, 16'h1111);
    wr_cnt = 0;
    a_valid = 1'b1; a_addr = 3'd0; a_data = 16'h0F0F;
    @(negedge clk);
    a_addr = 3'd1; a_data = 16'h1111;
    check("r0_q_h1", 32'(hazard1), 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    check("r0_pop_wite", 32'(wite), 32'd0);
    check("r0_pop_h1", 32'(hazard1), 32'd0);
    check("r0_pop_h2", 32'(hazard2), 32'd1);
    @(negedge clk);
    check("r0_r1_wite", 32'(wite), 32'd1);
    check("r0_r1_h1", 32'(hazard1), 32'd0);
    drain("r0_drain");
    check("r0_write_count", 32'(wr_cnt), 32'd1);
`else
    // Register 0 behaves like any other register.
    do_reset();
    chk_addr1 = 3'd0; chk_addr2 = 3'd1;
    expect_wr(3'd0, 16'h0A0A);
    a_valid = 1'b1; a_addr = 3'd0; a_data = 16'h0A0A;
    @(negedge clk);
    a_valid = 1'b0;
    check("r0_q_h1", 32'(hazard1), 32'd1);
    check("r0_q_h2", 32'(hazard2), 32'd0);
    @(negedge clk);
    check("r0_out_wite", 32'(wite), 32'd1);
    check("r0_out_h1", 32'(hazard1), 32'd1);
    @(negedge clk);
    check("r0_done_h1", 32'(hazard1), 32'd0);
    drain("r0_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
